uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, downstream of the memory stage. Stores to its address window push bytes into a transmit FIFO. A baud-rate FSM serialises the bytes onto a single `tx` line. Loads return FIFO and line status, so firmware can poll before writing, alongside the LED output.

---
 rtl/uart_tx_mmio.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with transmit FIFO and baud-rate FSM
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [7:0]          shift;
    logic [2:0]          bit_idx;
    logic [BAUD_W-1:0]   baud_cnt;
`ifdef UART_TX_PARITY_EN
    logic                parity_bit;
`endif

    logic full, empty, busy;
    logic push_req, clr_req, pop, push, drop;
    logic unused_wdata;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign push_req = sel & we & (addr == 4'h0);
    assign clr_req  = sel & we & (addr == 4'h4) & wdata[3];
    assign pop      = (state == IDLE) & ~empty;
    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_req) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        state    <= START;
                        tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // tx is registered, so drive the bit that lands after the shift.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            4'h4: begin
                rdata[0] = full;
                rdata[1] = empty;
                rdata[2] = busy;
                rdata[3] = overflow;
                rdata[4] = PARITY_EN;
            end
            4'h8: rdata[CNT_W-1:0] = count;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - randomized self-checking bench for uart_tx_mmio against a frame-timing model
module tb_uart_tx_mmio;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   FL  = 11 * C;
    localparam logic PEN = 1'b1;
`else
    localparam int   FL  = 10 * C;
    localparam logic PEN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;

    int checks = 0;
    int errors = 0;

    uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edge index, FIFO contents as a queue, and the frame currently on the line.
    int         ecnt = 0;
    logic [7:0] q[$];
    int         next_pop_ok = 0;
    logic       have_frame = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         cur_start = 0;
    logic       m_ovf = 1'b0;
    logic       rst_seen = 1'b0;

    always @(posedge clk) begin
        int   e;
        logic did_pop;
        logic set_ovf;
        e = ecnt + 1;
        if (reset) begin
            q.delete();
            have_frame  = 1'b0;
            next_pop_ok = e + 1;
            m_ovf       = 1'b0;
            rst_seen    = 1'b1;
        end else begin
            did_pop = (e >= next_pop_ok) && (q.size() > 0);
            set_ovf = 1'b0;
            if (did_pop) begin
                cur_byte    = q.pop_front();
                cur_start   = e;
                have_frame  = 1'b1;
                next_pop_ok = e + FL + 1;
            end
            if (sel && we && addr == 4'h0) begin
                if (q.size() < D) q.push_back(wdata[7:0]);
                else set_ovf = 1'b1;
            end
            if (set_ovf) m_ovf = 1'b1;
            else if (sel && we && addr == 4'h4 && wdata[3]) m_ovf = 1'b0;
        end
        ecnt = e;
    end

    function automatic logic exp_tx(int t);
        int k;
        if (!have_frame || t >= cur_start + FL) return 1'b1;
        k = (t - cur_start) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur_byte[k-1];
        if (k == 9 && PEN) return ^cur_byte;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        int   sz;
        logic busy;
        sz   = q.size();
        busy = have_frame && (ecnt < cur_start + FL);
        return {27'd0, PEN, m_ovf, busy, (sz == 0), (sz == D)};
    endfunction

    always @(negedge clk) begin
        if (rst_seen) begin
            checks++;
            if (tx !== exp_tx(ecnt)) begin
                errors++;
                $display("FAIL line_tx edge %0d got %b exp %b", ecnt, tx, exp_tx(ecnt));
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; addr = 4'h0;
    endtask

    task automatic wait_until(input int e);
        while (ecnt < e) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || exp_status()[2]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL drain_timeout got %0d cycles exp < 20000", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        addr = 4'h4; #1; checks++;
        if (rdata !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", rdata, 32'h2); end
        addr = 4'h8; #1; checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", rdata, 32'h0); end
        addr = 4'h0; #1; checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_txdata got %h exp %h", rdata, 32'h0); end
        addr = 4'hC; #1; checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_unmapped got %h exp %h", rdata, 32'h0); end
        addr = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int n;
        bus_write(4'h0, 32'h0000_00A5);
        n = ecnt;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL latency_pre got %b exp 1", tx); end
        @(negedge clk); checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL start_bit got %b exp 0", tx); end
        wait_until(n + 1 + C); checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL data_bit0 got %b exp 1", tx); end
        wait_until(n + 1 + 2 * C); checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL data_bit1 got %b exp 0", tx); end
        wait_until(n + FL);
        addr = 4'h4; #1; checks++;
        if (rdata[2] !== 1'b1) begin errors++; $display("FAIL busy_last got %b exp 1", rdata[2]); end
        wait_until(n + FL + 1);
        #1; checks++;
        if (rdata !== 32'h2 + {27'd0, PEN, 4'd0}) begin
            errors++; $display("FAIL busy_clear got %h exp %h", rdata, 32'h2 + {27'd0, PEN, 4'd0});
        end
        addr = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        sel = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h01;
        @(negedge clk); wdata = 32'h02;
        @(negedge clk); wdata = 32'h03;
        @(negedge clk); sel = 1'b0; we = 1'b0;
        n = ecnt - 2;
        addr = 4'h8; #1; checks++;
        if (rdata !== 32'd2) begin errors++; $display("FAIL b2b_count2 got %0d exp 2", rdata); end
        wait_until(n + 1 + FL); #1; checks++;
        if (tx !== 1'b1 || rdata !== 32'd2) begin
            errors++; $display("FAIL b2b_idle_gap got tx %b cnt %0d exp tx 1 cnt 2", tx, rdata);
        end
        wait_until(n + FL + 2); #1; checks++;
        if (tx !== 1'b0 || rdata !== 32'd1) begin
            errors++; $display("FAIL b2b_frame2 got tx %b cnt %0d exp tx 0 cnt 1", tx, rdata);
        end
        wait_until(n + 2 * FL + 3); #1; checks++;
        if (tx !== 1'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL b2b_frame3 got tx %b cnt %0d exp tx 0 cnt 0", tx, rdata);
        end
        addr = 4'h0;
        drain();
    endtask

    task automatic test_overflow();
        int p;
        sel = 1'b1; we = 1'b1; addr = 4'h0;
        for (int i = 0; i < 6; i++) begin
            wdata = $urandom;
            @(negedge clk);
        end
        sel = 1'b0; we = 1'b0;
        addr = 4'h8; #1; checks++;
        if (rdata !== 32'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", rdata); end
        addr = 4'h4; #1; checks++;
        if (rdata[3] !== 1'b1 || rdata[0] !== 1'b1 || rdata !== exp_status()) begin
            errors++; $display("FAIL ovf_status got %h exp %h", rdata, exp_status());
        end
        addr = 4'h0;
        bus_write(4'h4, 32'h8);
        addr = 4'h4; #1; checks++;
        if (rdata[3] !== 1'b0 || rdata[0] !== 1'b1) begin
            errors++; $display("FAIL ovf_clear got %h exp full=1 ovf=0", rdata);
        end
        addr = 4'h0;
        p = next_pop_ok;
        wait_until(p - 1);
        bus_write(4'h0, 32'h5A);
        addr = 4'h8; #1; checks++;
        if (rdata !== 32'd4) begin errors++; $display("FAIL full_push_pop_count got %0d exp 4", rdata); end
        addr = 4'h4; #1; checks++;
        if (rdata[3] !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf got %b exp 0", rdata[3]); end
        addr = 4'h0;
        drain();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) bus_write(4'h0, $urandom);
            else if (r == 4) bus_write(4'h4, $urandom);
            else if (r == 5) bus_write(($urandom_range(0, 1) != 0) ? 4'h8 : 4'hC, $urandom);
            else repeat ($urandom_range(1, 30)) @(negedge clk);
            if (i % 8 == 0) begin
                addr = 4'h4; #1; checks++;
                if (rdata !== exp_status()) begin
                    errors++; $display("FAIL rand_status got %h exp %h", rdata, exp_status());
                end
                addr = 4'h8; #1; checks++;
                if (rdata !== 32'(q.size())) begin
                    errors++; $display("FAIL rand_count got %0d exp %0d", rdata, q.size());
                end
                addr = 4'h0;
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw_low;
        bus_write(4'h0, 32'hC3);
        n = ecnt;
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'h99);
        wait_until(n + 1 + 3 * C);
        reset = 1'b1;
        @(negedge clk);
        addr = 4'h4; #1; checks++;
        if (tx !== 1'b1 || rdata !== (32'h2 | {27'd0, PEN, 4'd0})) begin
            errors++; $display("FAIL reset_mid got tx %b status %h exp tx 1 status 2", tx, rdata);
        end
        reset = 1'b0; addr = 4'h0;
        saw_low = 1'b0;
        repeat (3 * FL) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low) begin errors++; $display("FAIL reset_no_frames got low exp idle"); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        bus_write(4'h0, 32'h07);
        n = ecnt;
        wait_until(n + 1 + 9 * C); checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL parity_bit got %b exp 1", tx); end
        wait_until(n + 44);
        addr = 4'h4; #1; checks++;
        if (rdata[2] !== 1'b1 || rdata[4] !== 1'b1) begin
            errors++; $display("FAIL parity_len_busy got %h exp busy=1 bit4=1", rdata);
        end
        wait_until(n + 45); #1; checks++;
        if (rdata[2] !== 1'b0) begin errors++; $display("FAIL parity_len_idle got %b exp 0", rdata[2]); end
        addr = 4'h0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
